// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types, encodings and helpers for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Register usage of one in-flight instruction (18 bits).
    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] wr_addr;
        logic             is_load;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } slot_t;

    // True when slot s will write register x; $0 never matches.
    function automatic logic slot_match(input logic [REG_W-1:0] x, input slot_t s);
        return s.valid && s.wr_en && (s.wr_addr != '0) && (s.wr_addr == x);
    endfunction

    // Operand source for the EX instruction; the nearer producer (MEM) wins.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, input slot_t ex,
                                           input slot_t mem, input slot_t wb);
        if (!ex.valid)
            return FWD_RF;
        if (slot_match(src, mem) && !mem.is_load)
            return FWD_EXMEM;
        if (slot_match(src, wb))
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage request, pipeline control and counter signals of the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipeline_hazard_ctrl_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wr_en;
    logic [REG_W-1:0] id_wr_addr;
    logic             id_is_load;
    logic             ex_redirect;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
               id_is_load, ex_redirect,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
               id_is_load, ex_redirect,
        output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_shadow_slot.sv
// One pipeline-stage shadow of an instruction's register usage; kill loads a bubble.
module hazard_shadow_slot
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  kill,
    input  slot_t d,
    output slot_t q
);
    slot_t d_gated;

    // Killed entries keep their payload but are marked invalid.
    always_comb begin
        d_gated       = d;
        d_gated.valid = d.valid & ~kill;
    end

    // Stage register, cleared by active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst)
            q <= '0;
        else
            q <= d_gated;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, redirect flush and forwarding control for a 5-stage pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [2:0] SCNT_INIT = 3'(LOAD_LAT - 1);

    // Slot 0 = EX, 1 = MEM, 2 = WB.
    slot_t      slot_d    [3];
    slot_t      slot_q    [3];
    logic       slot_kill [3];

    state_t     state_reg, state_next;
    logic [2:0] scnt_reg, scnt_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    logic eff_run, load_use, stall;
    logic unused_wb;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            hazard_shadow_slot u_slot (
                .clk  (clk),
                .rst  (rst),
                .kill (slot_kill[gi]),
                .d    (slot_d[gi]),
                .q    (slot_q[gi])
            );
        end
    endgenerate

    // Shadow advance: ID feeds EX (bubbled on stall/redirect), EX->MEM->WB unconditionally.
    always_comb begin
        slot_d[0]    = '{valid: bus.id_valid, wr_en: bus.id_wr_en, wr_addr: bus.id_wr_addr,
                         is_load: bus.id_is_load, rs: bus.id_rs, rt: bus.id_rt};
        slot_d[1]    = slot_q[0];
        slot_d[2]    = slot_q[1];
        slot_kill[0] = bus.idex_bubble | ~bus.id_valid;
        slot_kill[1] = 1'b0;
        slot_kill[2] = 1'b0;
    end

    // Hazard detection, next-state and pipeline control; STALL with scnt==0 behaves as RUN
    // so a LOAD_LAT-cycle hazard stalls exactly LOAD_LAT cycles.
    always_comb begin
        eff_run  = (state_reg == ST_RUN) || (scnt_reg == 3'd0);
        load_use = bus.id_valid && slot_q[0].is_load &&
                   ((bus.id_use_rs && slot_match(bus.id_rs, slot_q[0])) ||
                    (bus.id_use_rt && slot_match(bus.id_rt, slot_q[0])));
        stall    = eff_run ? load_use : 1'b1;

        state_next      = state_reg;
        scnt_next       = scnt_reg;
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;

        if (bus.ex_redirect) begin
            state_next      = ST_RUN;
            scnt_next       = 3'd0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else begin
            if (stall) begin
                bus.pc_en       = 1'b0;
                bus.ifid_en     = 1'b0;
                bus.idex_bubble = 1'b1;
            end
            if (eff_run) begin
                state_next = load_use ? ST_STALL : ST_RUN;
                scnt_next  = load_use ? SCNT_INIT : 3'd0;
            end else begin
                scnt_next = scnt_reg - 3'd1;
            end
        end

        bus.fwd_a = fwd_sel(slot_q[0].rs, slot_q[0], slot_q[1], slot_q[2]);
        bus.fwd_b = fwd_sel(slot_q[0].rt, slot_q[0], slot_q[1], slot_q[2]);
    end

    // FSM state and stall countdown.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_RUN;
            scnt_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            scnt_reg  <= scnt_next;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall && !bus.ex_redirect && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (bus.ex_redirect && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt_reg;
    assign bus.flush_cnt = flush_cnt_reg;

    // WB-slot fields that only exist to keep the slot format uniform.
    assign unused_wb = ^{slot_q[2].is_load, slot_q[2].rs, slot_q[2].rt};
endmodule
